// File: rtl/reg_lock_tracker_if.sv
// Issue / write-back / lock-status bundle between the issue arbiter, the
// write-back stage and reg_lock_tracker.
interface reg_lock_tracker_if #(
  parameter int NR  = 32,
  parameter int NWB = 2
);
  localparam int RW = $clog2(NR);

  logic              flush_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic              issue_blocking_i;
  logic [RW-1:0]     issue_rd_i;
  logic              issue_mem_op_i;
  logic [NWB-1:0]    wb_valid_i;
  logic [NWB*RW-1:0] wb_rd_i;
  logic              blocking_done_i;
  logic              mem_done_i;
  logic [NR-1:0]     locks_o;
  logic              mem_busy_o;
  logic              wb_err_o;

  modport master (
    output flush_i, issue_valid_i, issue_blocking_i, issue_rd_i, issue_mem_op_i,
           wb_valid_i, wb_rd_i, blocking_done_i, mem_done_i,
    input  issue_ready_o, locks_o, mem_busy_o, wb_err_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_blocking_i, issue_rd_i, issue_mem_op_i,
           wb_valid_i, wb_rd_i, blocking_done_i, mem_done_i,
    output issue_ready_o, locks_o, mem_busy_o, wb_err_o
  );
endinterface

// File: rtl/reg_lock_tracker.sv
// Per-register outstanding-write counters plus blocking and memory-busy state;
// produces the registered lock mask and memory-busy flag for the grant checker.
module reg_lock_tracker #(
  parameter int NR    = 32,
  parameter int NWB   = 2,
  parameter int CNT_W = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  reg_lock_tracker_if.slave bus
);
  localparam int RW = $clog2(NR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN = 1'b0, BLOCK = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg  [NR];
  logic [CNT_W-1:0] cnt_next [NR];
  logic [NR-1:0]    locks_reg, locks_next;
  logic [NR-1:0]    err_vec;
  logic             mem_busy_reg, mem_busy_next;
  logic             wb_err_reg;
  logic             issue_ready;
  logic             fire;

  // Readiness looks only at the registered count: a release in the same
  // cycle does not unlock a saturated register.
  always_comb begin
    issue_ready = (state_reg == RUN) &&
                  !((bus.issue_rd_i != '0) && (cnt_reg[bus.issue_rd_i] == CNT_MAX));
  end

  assign fire = bus.issue_valid_i && issue_ready;

  always_comb begin
    state_next = state_reg;
    if (state_reg == RUN && fire && bus.issue_blocking_i)
      state_next = BLOCK;
    else if (state_reg == BLOCK && bus.blocking_done_i)
      state_next = RUN;
  end

  always_comb begin
    mem_busy_next = mem_busy_reg;
    if (fire && bus.issue_mem_op_i)
      mem_busy_next = 1'b1;
    else if (bus.mem_done_i)
      mem_busy_next = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_reg
      logic [CNT_W-1:0] cnt_nx;
      logic             err_nx;

      if (gi == 0) begin : g_zero
        // x0 is never tracked: no counting and no release errors.
        assign cnt_nx = '0;
        assign err_nx = 1'b0;
      end else begin : g_cnt
        always_comb begin
          int dec;
          int sum;
          dec = 0;
          for (int p = 0; p < NWB; p++) begin
            if (bus.wb_valid_i[p] && bus.wb_rd_i[p*RW +: RW] == RW'(gi))
              dec++;
          end
          sum = int'(cnt_reg[gi]) - dec;
          if (fire && !bus.issue_blocking_i && bus.issue_rd_i == RW'(gi))
            sum++;
          err_nx = 1'b0;
          if (sum < 0) begin
            err_nx = 1'b1;
            sum    = 0;
          end
          cnt_nx = sum[CNT_W-1:0];
        end
      end

      assign cnt_next[gi]   = cnt_nx;
      assign err_vec[gi]    = err_nx;
      assign locks_next[gi] = (state_next == BLOCK) || (cnt_nx != '0);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      state_reg    <= RUN;
      locks_reg    <= '0;
      mem_busy_reg <= 1'b0;
      wb_err_reg   <= 1'b0;
      for (int r = 0; r < NR; r++) cnt_reg[r] <= '0;
    end else begin
      state_reg    <= state_next;
      locks_reg    <= locks_next;
      mem_busy_reg <= mem_busy_next;
      wb_err_reg   <= |err_vec;
      for (int r = 0; r < NR; r++) cnt_reg[r] <= cnt_next[r];
    end
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.locks_o       = locks_reg;
  assign bus.mem_busy_o    = mem_busy_reg;
  assign bus.wb_err_o      = wb_err_reg;
endmodule
